// File: rtl/mem_access_seq.sv
// mem_access_seq: multicycle load/store sequencer for the CPU data-memory port.
// Loads zero-extend the low lanes; sub-word stores are done as read-modify-write.
module mem_access_seq #(
   parameter int MEM_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_mode,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   output logic        resp_err,
   output logic [2:0]  dbg_state
);

   // Handshake: a request transfers on the rising edge where req_valid and req_ready
   // are both high; req_ready is high only in IDLE. resp_valid is a one-cycle pulse
   // with no backpressure.

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD    = 3'd1,
      S_RWAIT = 3'd2,
      S_WR    = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   localparam logic [1:0] MODE_WORD = 2'b00;
   localparam logic [1:0] MODE_HALF = 2'b01;
   localparam logic [1:0] MODE_BYTE = 2'b10;
   localparam logic [1:0] MODE_ILL  = 2'b11;
   localparam logic [2:0] CNT_INIT  = 3'(MEM_LAT - 1);

   state_t      state;
   logic [2:0]  cnt;
   logic        cap_write;
   logic [1:0]  cap_mode;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;

   function automatic logic [31:0] merge(input logic [1:0] mode, input logic [31:0] old,
                                         input logic [31:0] wd);
      case (mode)
         MODE_HALF: merge = {old[31:16], wd[15:0]};
         MODE_BYTE: merge = {old[31:8], wd[7:0]};
         default:   merge = wd;
      endcase
   endfunction

   function automatic logic [31:0] extract(input logic [1:0] mode, input logic [31:0] old);
      case (mode)
         MODE_HALF: extract = {16'b0, old[15:0]};
         MODE_BYTE: extract = {24'b0, old[7:0]};
         default:   extract = old;
      endcase
   endfunction

   // Gated by reset so ready stays low while reset is asserted.
   assign req_ready = (state == S_IDLE) && reset;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         cnt        <= 3'd0;
         cap_write  <= 1'b0;
         cap_mode   <= 2'b00;
         cap_addr   <= 32'd0;
         cap_wdata  <= 32'd0;
         mem_addr   <= 32'd0;
         mem_rd     <= 1'b0;
         mem_wr     <= 1'b0;
         mem_wdata  <= 32'd0;
         resp_valid <= 1'b0;
         resp_data  <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  cap_write <= req_write;
                  cap_mode  <= req_mode;
                  cap_addr  <= req_addr;
                  cap_wdata <= req_wdata;
                  if (req_mode == MODE_ILL) begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (req_write && (req_mode == MODE_WORD)) begin
                     state     <= S_WR;
                     mem_wr    <= 1'b1;
                     mem_addr  <= req_addr;
                     mem_wdata <= req_wdata;
                  end else begin
                     state    <= S_RD;
                     mem_rd   <= 1'b1;
                     mem_addr <= req_addr;
                  end
               end
            end
            S_RD: begin
               mem_rd   <= 1'b0;
               mem_addr <= 32'd0;
               cnt      <= CNT_INIT;
               state    <= S_RWAIT;
            end
            S_RWAIT: begin
               // Read data is valid in the cycle the countdown reaches zero.
               if (cnt == 3'd0) begin
                  if (cap_write) begin
                     state     <= S_WR;
                     mem_wr    <= 1'b1;
                     mem_addr  <= cap_addr;
                     mem_wdata <= merge(cap_mode, mem_rdata, cap_wdata);
                  end else begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_data  <= extract(cap_mode, mem_rdata);
                  end
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            S_WR: begin
               mem_wr     <= 1'b0;
               mem_addr   <= 32'd0;
               mem_wdata  <= 32'd0;
               resp_valid <= 1'b1;
               state      <= S_RESP;
            end
            S_RESP: begin
               resp_valid <= 1'b0;
               resp_data  <= 32'd0;
               resp_err   <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
